// File: rtl/sram_1rw1r_mask.sv
// sram_1rw1r_mask: byte-masked 1RW + 1R behavioural SRAM
// with a 1- or 2-edge registered read pipeline and valid strobes.
module sram_1rw1r_mask #(
  parameter  int DATA_WIDTH   = 32,
  parameter  int ADDR_WIDTH   = 7,
  parameter  int READ_LATENCY = 1,
  localparam int WMASK_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                   clk0,
  input  logic                   rst_n,
  input  logic                   csb0,
  input  logic                   web0,
  input  logic [WMASK_WIDTH-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0]  addr0,
  input  logic [DATA_WIDTH-1:0]  din0,
  output logic [DATA_WIDTH-1:0]  dout0,
  output logic                   dout0_valid,
  input  logic                   csb1,
  input  logic [ADDR_WIDTH-1:0]  addr1,
  output logic [DATA_WIDTH-1:0]  dout1,
  output logic                   dout1_valid
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_lat
    $error("sram_1rw1r_mask: READ_LATENCY must be 1 or 2");
  end

  if (DATA_WIDTH % 8 != 0) begin : g_bad_dw
    $error("sram_1rw1r_mask: DATA_WIDTH must be a multiple of 8");
  end

  logic [DATA_WIDTH-1:0]  mem_q [DEPTH];
  logic [WMASK_WIDTH-1:0] wbe;
  logic [1:0]             rd_req;
  logic [DATA_WIDTH-1:0]  rd_word [2];

  logic [1:0]             s1_vld_q, s1_vld_d;
  logic [DATA_WIDTH-1:0]  s1_dat_q [2];
  logic [DATA_WIDTH-1:0]  s1_dat_d [2];

  // Decode requests; writes are gated off while reset is held.
  always_comb begin
    wbe = '0;
    if (rst_n && !csb0 && !web0) wbe = wmask0;
    rd_req[0]  = !csb0 && web0;
    rd_req[1]  = !csb1;
    rd_word[0] = mem_q[addr0];
    rd_word[1] = mem_q[addr1];
  end

  // Array update; reads above see the pre-edge word (read-before-write).
  always_ff @(posedge clk0) begin
    for (int i = 0; i < WMASK_WIDTH; i++) begin
      if (wbe[i]) mem_q[addr0][8*i +: 8] <= din0[8*i +: 8];
    end
  end

  // First read stage: capture on request, otherwise hold last word.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      s1_vld_d[p] = rd_req[p];
      s1_dat_d[p] = rd_req[p] ? rd_word[p] : s1_dat_q[p];
    end
  end

  // First read stage registers with synchronous clear.
  always_ff @(posedge clk0) begin
    if (!rst_n) begin
      s1_vld_q    <= '0;
      s1_dat_q[0] <= '0;
      s1_dat_q[1] <= '0;
    end else begin
      s1_vld_q    <= s1_vld_d;
      s1_dat_q[0] <= s1_dat_d[0];
      s1_dat_q[1] <= s1_dat_d[1];
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic [1:0]            o_vld_q, o_vld_d;
    logic [DATA_WIDTH-1:0] o_dat_q [2];
    logic [DATA_WIDTH-1:0] o_dat_d [2];

    // Output stage: forward stage-1 word only when it was a real read.
    always_comb begin
      o_vld_d = s1_vld_q;
      for (int p = 0; p < 2; p++) begin
        o_dat_d[p] = s1_vld_q[p] ? s1_dat_q[p] : o_dat_q[p];
      end
    end

    // Output stage registers with synchronous clear.
    always_ff @(posedge clk0) begin
      if (!rst_n) begin
        o_vld_q    <= '0;
        o_dat_q[0] <= '0;
        o_dat_q[1] <= '0;
      end else begin
        o_vld_q    <= o_vld_d;
        o_dat_q[0] <= o_dat_d[0];
        o_dat_q[1] <= o_dat_d[1];
      end
    end

    assign dout0       = o_dat_q[0];
    assign dout1       = o_dat_q[1];
    assign dout0_valid = o_vld_q[0];
    assign dout1_valid = o_vld_q[1];
  end else begin : g_lat1
    assign dout0       = s1_dat_q[0];
    assign dout1       = s1_dat_q[1];
    assign dout0_valid = s1_vld_q[0];
    assign dout1_valid = s1_vld_q[1];
  end

endmodule

// File: tb/tb_sram_1rw1r_mask.sv
// tb_sram_1rw1r_mask: random + directed bench for both read
// latencies, checked against a word-array reference model.
module tb_sram_1rw1r_mask;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        csb0, web0, csb1;
  logic [3:0]  wmask0;
  logic [6:0]  addr0, addr1;
  logic [31:0] din0;

  logic [31:0] dout0_a, dout1_a, dout0_b, dout1_b;
  logic        dv0_a, dv1_a, dv0_b, dv1_b;

  int checks = 0;
  int errors = 0;

  logic [31:0] refm [128];
  logic        prv_rd  [2];
  logic [31:0] prv_dat [2];
  logic        ev1 [2];
  logic        ev2 [2];
  logic [31:0] ed1 [2];
  logic [31:0] ed2 [2];

  always #5 clk = ~clk;

  sram_1rw1r_mask #(.READ_LATENCY(1)) u_lat1 (
    .clk0(clk), .rst_n(rst_n),
    .csb0(csb0), .web0(web0), .wmask0(wmask0),
    .addr0(addr0), .din0(din0),
    .dout0(dout0_a), .dout0_valid(dv0_a),
    .csb1(csb1), .addr1(addr1),
    .dout1(dout1_a), .dout1_valid(dv1_a)
  );

  sram_1rw1r_mask #(.READ_LATENCY(2)) u_lat2 (
    .clk0(clk), .rst_n(rst_n),
    .csb0(csb0), .web0(web0), .wmask0(wmask0),
    .addr0(addr0), .din0(din0),
    .dout0(dout0_b), .dout0_valid(dv0_b),
    .csb1(csb1), .addr1(addr1),
    .dout1(dout1_b), .dout1_valid(dv1_b)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input logic r, input logic c0, input logic w0,
                     input logic [3:0] m, input logic [6:0] a0,
                     input logic [31:0] d, input logic c1,
                     input logic [6:0] a1);
    logic        cr [2];
    logic [31:0] cd [2];
    rst_n = r; csb0 = c0; web0 = w0; wmask0 = m;
    addr0 = a0; din0 = d; csb1 = c1; addr1 = a1;
    @(posedge clk);
    cr[0] = r && !c0 && w0;
    cr[1] = r && !c1;
    cd[0] = refm[a0];
    cd[1] = refm[a1];
    for (int p = 0; p < 2; p++) begin
      ev1[p] = cr[p];
      ev2[p] = prv_rd[p] && r;
      if (!r) ed1[p] = 32'h0;
      else if (ev1[p]) ed1[p] = cd[p];
      if (!r) ed2[p] = 32'h0;
      else if (ev2[p]) ed2[p] = prv_dat[p];
      prv_rd[p]  = cr[p];
      prv_dat[p] = cd[p];
    end
    if (r && !c0 && !w0) begin
      for (int b = 0; b < 4; b++) begin
        if (m[b]) refm[a0][8*b +: 8] = d[8*b +: 8];
      end
    end
    #1;
    check("L1_v0", {31'b0, dv0_a}, {31'b0, ev1[0]});
    check("L1_v1", {31'b0, dv1_a}, {31'b0, ev1[1]});
    check("L2_v0", {31'b0, dv0_b}, {31'b0, ev2[0]});
    check("L2_v1", {31'b0, dv1_b}, {31'b0, ev2[1]});
    check("L1_d0", dout0_a, ed1[0]);
    check("L1_d1", dout1_a, ed1[1]);
    check("L2_d0", dout0_b, ed2[0]);
    check("L2_d1", dout1_b, ed2[1]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 1, 1, 4'h0, 0, 0, 1, 0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      prv_rd[i] = 1'b0; prv_dat[i] = '0;
      ev1[i] = 1'b0; ev2[i] = 1'b0;
      ed1[i] = '0; ed2[i] = '0;
    end

    cyc(0, 1, 1, 4'h0, 0, 0, 1, 0);

    for (int i = 0; i < 128; i++) begin
      cyc(1, 0, 0, 4'hF, 7'(i), 32'h100 + i, 1, 0);
    end
    cyc(1, 0, 0, 4'hF, 127, 32'hCAFEF00D, 1, 0);
    cyc(1, 0, 0, 4'hF, 9, 32'hAAAA0000, 1, 0);
    cyc(1, 0, 0, 4'hF, 3, 32'h33333333, 1, 0);

    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 4'hF, 0, 0, 0, 0);
    cyc(0, 0, 0, 4'hF, 3, 32'hBAD0BAD0, 1, 0);
    check("rst_dout0", dout0_b, 32'h0);

    for (int i = 0; i < 8; i++) begin
      cyc(1, 0, 1, 4'h0, 7'(i), 0, 0, 7'(7 - i));
    end
    idle(3);

    cyc(1, 0, 0, 4'hF, 5, 32'hDEADBEEF, 1, 0);
    cyc(1, 0, 0, 4'b0101, 5, 32'h11223344, 1, 0);
    cyc(1, 0, 1, 4'h0, 5, 0, 1, 0);
    check("mask_L1", dout0_a, 32'hDE22BE44);
    cyc(1, 0, 0, 4'h0, 5, 32'hFFFFFFFF, 1, 0);
    check("mask_L2", dout0_b, 32'hDE22BE44);
    cyc(1, 0, 1, 4'h0, 5, 0, 1, 0);
    check("mask0_L1", dout0_a, 32'hDE22BE44);

    cyc(1, 0, 0, 4'hF, 9, 32'h5555FFFF, 0, 9);
    check("coll_old", dout1_a, 32'hAAAA0000);
    cyc(1, 1, 1, 4'h0, 0, 0, 0, 9);
    check("coll_new", dout1_a, 32'h5555FFFF);
    idle(2);

    cyc(1, 0, 1, 4'h0, 4, 0, 1, 0);
    cyc(0, 1, 1, 4'h0, 0, 0, 1, 0);
    check("mid_v_L2", {31'b0, dv0_b}, 32'h0);
    check("mid_d_L2", dout0_b, 32'h0);
    idle(2);
    cyc(1, 0, 1, 4'h0, 3, 0, 1, 0);
    check("rst_wr_a3", dout0_a, 32'h33333333);

    cyc(1, 0, 1, 4'h0, 127, 0, 1, 0);
    idle(4);
    check("hold_L1", dout0_a, 32'hCAFEF00D);
    check("hold_L2", dout0_b, 32'hCAFEF00D);

    cyc(1, 0, 0, 4'hF, 0, 32'h0BAD_F00D, 1, 0);
    cyc(1, 0, 0, 4'hF, 127, 32'h7F7F_0001, 1, 0);
    cyc(1, 0, 1, 4'h0, 0, 0, 0, 127);
    cyc(1, 0, 1, 4'h0, 127, 0, 0, 0);
    check("bnd_p0", dout0_a, 32'h7F7F_0001);
    check("bnd_p1", dout1_a, 32'h0BAD_F00D);
    idle(2);

    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom % 60) != 0,
          ($urandom % 4) == 0,
          ($urandom % 3) != 0,
          4'($urandom),
          7'($urandom),
          $urandom,
          ($urandom % 4) == 0,
          7'($urandom));
    end
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_1rw1r_mask.md
Name: sram_1rw1r_mask

Overview:
- Parametrised behavioural SRAM, next generation of the single-port OpenRAM-style model.
- Adds a second read-only port, per-byte write masking, and a configurable registered read latency with a read-valid strobe.
- Adds a synchronous reset for the output/control pipeline.
- Sits behind the core's instruction/data memory interfaces: port 0 for load/store, port 1 for fetch or debug read.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8
ADDR_WIDTH, 7, address width; depth = 1 << ADDR_WIDTH (128 words)
WMASK_WIDTH, DATA_WIDTH/8, number of byte-enable bits (derived, not overridden)
READ_LATENCY, 1, rising edges from request sample to data valid; legal values 1 or 2; any other value is an elaboration error

Ports:
clk0  input  1  clock; all activity on rising edge
rst_n  input  1  synchronous active-low reset
csb0  input  1  port 0 chip select, active low
web0  input  1  port 0 write enable, active low
wmask0  input  WMASK_WIDTH  port 0 byte write enables, active high; bit i covers din0[8i+7:8i]
addr0  input  ADDR_WIDTH  port 0 address
din0  input  DATA_WIDTH  port 0 write data
dout0  output  DATA_WIDTH  port 0 read data
dout0_valid  output  1  pulses high for exactly one cycle per completed port 0 read
csb1  input  1  port 1 chip select, active low (read-only port)
addr1  input  ADDR_WIDTH  port 1 address
dout1  output  DATA_WIDTH  port 1 read data
dout1_valid  output  1  pulses high for exactly one cycle per completed port 1 read

Behaviour:
- Reset is synchronous and active-low; it applies on any rising edge with rst_n=0.
  - dout0, dout1 <= 0.
  - dout0_valid, dout1_valid <= 0.
  - All in-flight read pipeline stages are cleared; a read sampled before reset never produces valid.
  - Memory array contents are NOT reset.
  - Any write presented at an edge with rst_n=0 is suppressed.
- Request sampling: at rising edge t, csb/web/wmask/addr/din are sampled.
- Port 0 write (csb0=0, web0=0):
  - At edge t, each byte i with wmask0[i]=1 is written into mem[addr0]; unmasked bytes are unchanged.
  - wmask0=0 is a legal no-op write.
  - A write produces no read: dout0 holds its value and dout0_valid is not asserted for it.
- Port 0 read (csb0=0, web0=1): mem[addr0] is captured at edge t.
- Port 1 read (csb1=0): mem[addr1] is captured at edge t.
- Read latency:
  - READ_LATENCY=1: dout/valid update at edge t; data is visible in the cycle after t.
  - READ_LATENCY=2: one extra output register stage; dout/valid update at edge t+1.
  - Fully pipelined: back-to-back reads every cycle are allowed, one valid pulse each, in request order.
- Idle port (csb=1): valid deasserts at its pipeline slot; dout holds its last read value (no X-driving, unlike the previous model).
- Collisions:
  - Port 1 reading the address written by port 0 at the same edge returns the OLD word (read-before-write, all bytes).
  - Port 0 read following a write to the same address on the next edge returns the NEW word.
- Address wrap: depth is a power of two, so every address is in range; no out-of-range handling.
- Ports are independent; there is no arbitration and no stall or back-pressure.
- No $display tracing in synthesis view; simulation-only tracing is guarded by a define.

Test Plan:
- Reset/hold: hold rst_n=0 for 3 edges with csb0=csb1=0 -> dout0=dout1=0 and both valids 0 throughout. Release rst_n -> first valid appears exactly READ_LATENCY edges after the first sampled read.
- Masked write: write 0xDEADBEEF to addr 5 with wmask=4'hF, then 0x11223344 with wmask=4'b0101, then read addr 5 -> 0xDE22BE44. Write with wmask=0 leaves 0xDE22BE44.
- Latency and pipelining: for READ_LATENCY=1 and 2, issue reads of addr 0..7 on consecutive cycles (preloaded data = 0x100+addr) -> 8 contiguous valid pulses, data 0x100..0x107 in order, first valid exactly READ_LATENCY edges after the first request.
- Collision: mem[9]=0xAAAA0000; at the same edge port 0 writes 0x5555FFFF to addr 9 and port 1 reads addr 9 -> dout1=0xAAAA0000. Port 1 read on the next edge -> 0x5555FFFF.
- Reset mid-flight (READ_LATENCY=2): issue read at edge t, drive rst_n=0 at edge t+1 -> dout0_valid never asserts for that read and dout0=0. A write to addr 3 presented with rst_n=0 leaves mem[3] unchanged.
- Hold and boundary: read addr 127 (0xCAFEF00D), then csb0=1 for 4 cycles -> dout0 stays 0xCAFEF00D, dout0_valid=0. Write and read addr 0 and 127 on both ports succeed.
